// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11 device clocks, ACK check.
// Reports open-drain pull-down enables; the top level builds the tri-state pads.
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ    = 100_000_000,
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  // CLK_FREQ_HZ only documents the intended clock; a non-positive value is meaningless.
  if (CLK_FREQ_HZ <= 0) begin : g_bad_clk_freq
  end

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             clk_meta, clk_s, clk_s_d;
  logic             data_meta, data_s;
  logic             fall;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       frame;      // {stop, parity, data[7:0]}, shifted LSB first
  logic             ack_ok_r;
  logic             active;
  logic             timeout;
  logic             data_oe_next;

  assign fall    = clk_s_d & ~clk_s;
  assign active  = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  // A fall in the same cycle restarts the window, so it beats the timeout.
  assign timeout = active && !fall && (cnt == TIMEOUT_LAST);

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (tx_valid && tx_ready) state_next = S_INHIBIT;
      S_INHIBIT:   if (cnt == INHIBIT_LAST) state_next = S_REQ;
      S_REQ:       state_next = S_SEND;
      S_SEND: begin
        if (timeout)                       state_next = S_IDLE;
        else if (fall && bit_cnt == 4'd9)  state_next = S_ACK;
      end
      S_ACK: begin
        if (timeout)   state_next = S_IDLE;
        else if (fall) state_next = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (timeout)              state_next = S_IDLE;
        else if (clk_s && data_s) state_next = S_DONE;
      end
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // The start bit set in REQ is held into SEND until the first device fall.
  always_comb begin
    data_oe_next = 1'b0;
    if (state_next == S_REQ)
      data_oe_next = 1'b1;
    else if (state_next == S_SEND)
      data_oe_next = (state == S_SEND && fall) ? ~frame[0] : ps2_data_oe;
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset here is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_s_d   <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_s     <= clk_meta;
      clk_s_d   <= clk_s;
      data_meta <= ps2_data_in;
      data_s    <= data_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      ack_ok_r    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      tx_ready    <= 1'b1;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      error       <= 1'b0;
    end else begin
      state <= state_next;

      // One counter serves both the inhibit length and the device-clock watchdog.
      if (state_next != state || (active && fall))
        cnt <= '0;
      else if (state == S_INHIBIT || active)
        cnt <= cnt + CNT_W'(1);

      if (state == S_IDLE && tx_valid && tx_ready)
        frame <= {1'b1, ~^tx_data, tx_data};
      else if (state == S_SEND && fall)
        frame <= {1'b1, frame[9:1]};

      if (state_next == S_SEND && state != S_SEND)
        bit_cnt <= '0;
      else if (state == S_SEND && fall)
        bit_cnt <= bit_cnt + 4'd1;

      if (state == S_ACK && fall)
        ack_ok_r <= ~data_s;

      ps2_clk_oe  <= (state_next == S_INHIBIT) || (state_next == S_REQ);
      ps2_data_oe <= data_oe_next;
      busy        <= (state_next != S_IDLE);
      tx_ready    <= (state_next == S_IDLE);
      done        <= (state_next == S_DONE);
      ack_ok      <= (state_next == S_DONE) ? ack_ok_r : 1'b0;
      error       <= timeout;
    end
  end

endmodule
